mem_access_queue: RTL and testbench

Parametrised data-SRAM access unit between the MEM stage and the data-side SRAM-like bus. It replaces the single-outstanding request logic with three parts: a one-entry issue slot, an in-order in-flight buffer of DEPTH entries, and a response port with backpressure. This allows up to DEPTH loads/stores in flight while responses return in request order. Flush kills responses of in-flight requests without breaking the bus protocol.

---
 rtl/mem_pkg.sv | 44 ++++
 rtl/mem_inflight_buf.sv | 101 ++++++++++
 rtl/mem_access_queue.sv | 136 +++++++++++++
 tb/tb_mem_access_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings, buffer entry type and load extension helper
// Contents: op encodings (OP_*), bus size encodings (SZ_*), entry_t for the
// in-flight buffer, load_ext() which picks and extends the addressed lane.
package mem_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Tag is kept in a separate array because its width is a module parameter.
  typedef struct packed {
    logic        wr;
    logic [2:0]  op;
    logic [1:0]  lo;
    logic        kill;
    logic        done;
    logic [31:0] data;
  } entry_t;

  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] lo,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{lo, 3'b000} +: 8];
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_B:    r = {{24{b[7]}}, b};
      OP_BU:   r = {24'b0, b};
      OP_H:    r = {{16{h[15]}}, h};
      OP_HU:   r = {16'b0, h};
      OP_W:    r = rdata;
      default: r = rdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_inflight_buf.sv
// rtl/mem_inflight_buf.sv - in-order buffer of requests accepted by the bus
// Ports: alloc_* writes the tail entry; fill/fill_data completes the oldest
// not-done entry (its wr/op/lo are exposed for extension); head_* is the
// response port; flush kills every entry; full and cnt report occupancy.
module mem_inflight_buf
  import mem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc,
  input  logic             alloc_wr,
  input  logic [2:0]       alloc_op,
  input  logic [1:0]       alloc_lo,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             alloc_kill,
  input  logic             fill,
  input  logic [31:0]      fill_data,
  output logic             fill_avail,
  output logic             fill_wr,
  output logic [2:0]       fill_op,
  output logic [1:0]       fill_lo,
  output logic             head_valid,
  input  logic             head_ready,
  output logic             head_wr,
  output logic [31:0]      head_data,
  output logic [TAG_W-1:0] head_tag,
  output logic             full,
  output logic [CNT_W-1:0] cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  entry_t           ent [DEPTH];
  logic [TAG_W-1:0] tag [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PTR_W-1:0] head_ptr, done_ptr, tail_ptr;
  logic             fill_fire, pop;

  // Entries between head and done_ptr are all done, so done_ptr names the
  // oldest outstanding one whenever it points at a valid, not-done entry.
  assign fill_avail = vld[done_ptr] & ~ent[done_ptr].done;
  assign fill_fire  = fill & fill_avail;
  assign fill_wr    = ent[done_ptr].wr;
  assign fill_op    = ent[done_ptr].op;
  assign fill_lo    = ent[done_ptr].lo;

  assign head_valid = vld[head_ptr] & ent[head_ptr].done & ~ent[head_ptr].kill;
  assign head_wr    = ent[head_ptr].wr;
  assign head_data  = ent[head_ptr].data;
  assign head_tag   = tag[head_ptr];
  // Killed heads retire silently without waiting for head_ready.
  assign pop        = vld[head_ptr] & ent[head_ptr].done & (ent[head_ptr].kill | head_ready);
  assign full       = (cnt == DEPTH_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld      <= '0;
      head_ptr <= '0;
      done_ptr <= '0;
      tail_ptr <= '0;
      cnt      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
        tag[i] <= '0;
      end
    end else begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) ent[i].kill <= 1'b1;
      end
      if (fill_fire) begin
        ent[done_ptr].data <= fill_data;
        ent[done_ptr].done <= 1'b1;
        done_ptr           <= done_ptr + 1'b1;
      end
      if (pop) begin
        vld[head_ptr] <= 1'b0;
        head_ptr      <= head_ptr + 1'b1;
      end
      // Alloc only happens when not full, so tail never collides with head or done_ptr.
      if (alloc) begin
        ent[tail_ptr] <= '{wr: alloc_wr, op: alloc_op, lo: alloc_lo,
                           kill: alloc_kill, done: 1'b0, data: 32'b0};
        tag[tail_ptr] <= alloc_tag;
        vld[tail_ptr] <= 1'b1;
        tail_ptr      <= tail_ptr + 1'b1;
      end
      case ({alloc, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_queue.sv
// rtl/mem_access_queue.sv - pipelined data-SRAM access unit with in-order responses
// Ports: req_* request from MEM stage (valid/ready); data_sram_* SRAM-like bus;
// resp_* in-order response with backpressure; flush kills outstanding work;
// inflight_cnt / busy report occupancy.
module mem_access_queue
  import mem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             data_sram_req,
  output logic             data_sram_wr,
  output logic [1:0]       data_sram_size,
  output logic [3:0]       data_sram_wstrb,
  output logic [31:0]      data_sram_addr,
  output logic [31:0]      data_sram_wdata,
  input  logic             data_sram_addr_ok,
  input  logic             data_sram_data_ok,
  input  logic [31:0]      data_sram_rdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_wr,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic [CNT_W-1:0] inflight_cnt,
  output logic             busy
);

  logic             slot_valid, slot_wr, slot_kill;
  logic [2:0]       slot_op;
  logic [31:0]      slot_addr, slot_wdata;
  logic [TAG_W-1:0] slot_tag;
  logic             buf_full, fire, accept;
  logic             fill_avail, fill_wr;
  logic [2:0]       fill_op;
  logic [1:0]       fill_lo;
  logic [31:0]      fill_data;

  // Occupancy only rises through this request's own addr_ok, so once raised
  // data_sram_req and the slot contents hold until the bus accepts.
  assign data_sram_req = slot_valid & ~buf_full;
  assign fire          = data_sram_req & data_sram_addr_ok;
  assign req_ready     = (~slot_valid | fire) & ~flush;
  assign accept        = req_valid & req_ready;
  assign busy          = slot_valid | (inflight_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= 1'b0;
      slot_wr    <= 1'b0;
      slot_op    <= OP_B;
      slot_addr  <= '0;
      slot_wdata <= '0;
      slot_tag   <= '0;
      slot_kill  <= 1'b0;
    end else if (accept) begin
      slot_valid <= 1'b1;
      slot_wr    <= req_wr;
      slot_op    <= req_op;
      slot_addr  <= req_addr;
      slot_wdata <= req_wdata;
      slot_tag   <= req_tag;
      slot_kill  <= 1'b0;
    end else if (fire) begin
      slot_valid <= 1'b0;
    end else if (flush) begin
      // A request already on the bus must finish its handshake; one still
      // waiting for buffer space has never been seen by the bus and is dropped.
      if (!data_sram_req) slot_valid <= 1'b0;
      slot_kill <= 1'b1;
    end
  end

  always_comb begin
    data_sram_wr    = slot_wr;
    data_sram_size  = slot_op[1:0];
    data_sram_addr  = slot_addr;
    data_sram_wstrb = 4'b1111;
    data_sram_wdata = slot_wdata;
    case (slot_op[1:0])
      SZ_B: begin
        data_sram_wstrb = 4'b0001 << slot_addr[1:0];
        data_sram_wdata = {4{slot_wdata[7:0]}};
      end
      SZ_H: begin
        data_sram_wstrb = slot_addr[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{slot_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!slot_wr) data_sram_wstrb = 4'b0000;
  end

  assign fill_data = fill_wr ? 32'b0 : load_ext(fill_op, fill_lo, data_sram_rdata);

  mem_inflight_buf #(
    .DEPTH(DEPTH),
    .TAG_W(TAG_W),
    .CNT_W(CNT_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .alloc     (fire),
    .alloc_wr  (slot_wr),
    .alloc_op  (slot_op),
    .alloc_lo  (slot_addr[1:0]),
    .alloc_tag (slot_tag),
    .alloc_kill(slot_kill | flush),
    .fill      (data_sram_data_ok),
    .fill_data (fill_data),
    .fill_avail(fill_avail),
    .fill_wr   (fill_wr),
    .fill_op   (fill_op),
    .fill_lo   (fill_lo),
    .head_valid(resp_valid),
    .head_ready(resp_ready),
    .head_wr   (resp_wr),
    .head_data (resp_data),
    .head_tag  (resp_tag),
    .full      (buf_full),
    .cnt       (inflight_cnt)
  );

endmodule

// File: tb/tb_mem_access_queue.sv
// tb/tb_mem_access_queue.sv - self-checking bench for mem_access_queue
module tb_mem_access_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wr;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_tag;
  logic        flush;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        resp_valid, resp_ready, resp_wr;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic [1:0]  inflight_cnt;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_queue dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag), .flush(flush),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_wr(resp_wr),
    .resp_data(resp_data), .resp_tag(resp_tag),
    .inflight_cnt(inflight_cnt), .busy(busy)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  tag;
    logic [3:0]  strb;
    logic [31:0] bus_wdata;
    logic [1:0]  size;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] tag);
    req_valid = 1'b1;
    req_wr    = wr;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_tag   = tag;
  endtask

  // One isolated transaction: accept, addr_ok next cycle, data_ok the one after.
  task automatic run_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    @(negedge clk);
    set_req(v.wr, v.op, v.addr, v.wdata, v.tag);
    chk({s, "_req_ready"}, req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk({s, "_bus_req"}, data_sram_req, 1);
    chk({s, "_bus_wr"}, data_sram_wr, v.wr);
    chk({s, "_bus_addr"}, data_sram_addr, v.addr);
    chk({s, "_bus_size"}, data_sram_size, v.size);
    chk({s, "_bus_strb"}, data_sram_wstrb, v.strb);
    if (v.wr) chk({s, "_bus_wdata"}, data_sram_wdata, v.bus_wdata);
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    chk({s, "_req_dropped"}, data_sram_req, 0);
    chk({s, "_resp_early"}, resp_valid, 0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = v.rdata;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    chk({s, "_resp_valid"}, resp_valid, 1);
    chk({s, "_resp_data"}, resp_data, v.data);
    chk({s, "_resp_wr"}, resp_wr, v.wr);
    chk({s, "_resp_tag"}, resp_tag, v.tag);
    @(negedge clk);
    chk({s, "_resp_pop"}, resp_valid, 0);
    chk({s, "_idle"}, busy, 0);
  endtask

  initial begin
    //          wr    op      addr          wdata         rdata         tag    strb     bus_wdata     size  data
    vecs[0] = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_FF00, 5'd3,  4'b0000, 32'h0,        2'd0, 32'hFFFF_FF80};
    vecs[1] = '{1'b1, 3'b001, 32'h0000_1002, 32'h0000_1234, 32'hFFFF_FFFF, 5'd9,  4'b1100, 32'h1234_1234, 2'd1, 32'h0};
    vecs[2] = '{1'b0, 3'b100, 32'h0000_2001, 32'h0,        32'h0000_8000, 5'd10, 4'b0000, 32'h0,        2'd0, 32'h0000_0080};
    vecs[3] = '{1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'h8001_0000, 5'd11, 4'b0000, 32'h0,        2'd1, 32'hFFFF_8001};
    vecs[4] = '{1'b0, 3'b101, 32'h0000_2000, 32'h0,        32'h1234_F00D, 5'd12, 4'b0000, 32'h0,        2'd1, 32'h0000_F00D};
    vecs[5] = '{1'b0, 3'b010, 32'h0000_3000, 32'h0,        32'hDEAD_BEEF, 5'd13, 4'b0000, 32'h0,        2'd2, 32'hDEAD_BEEF};
    vecs[6] = '{1'b1, 3'b000, 32'h0000_4001, 32'h0000_00AB, 32'h0,        5'd14, 4'b0010, 32'hABAB_ABAB, 2'd0, 32'h0};
    vecs[7] = '{1'b1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 32'h0,        5'd15, 4'b1111, 32'hCAFE_F00D, 2'd2, 32'h0};
    vecs[8] = '{1'b0, 3'b001, 32'h0000_2000, 32'h0,        32'h0000_7FFF, 5'd16, 4'b0000, 32'h0,        2'd1, 32'h0000_7FFF};

    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_op = 3'b0; req_addr = '0;
    req_wdata = '0; req_tag = '0; flush = 1'b0; data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_bus_req", data_sram_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_cnt", inflight_cnt, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Back-to-back fill, full buffer, backpressure, in-order drain.
    @(negedge clk);
    resp_ready = 1'b0; data_sram_addr_ok = 1'b1;
    set_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd1);
    @(negedge clk);
    chk("b2b_req_a", data_sram_addr, 32'h10);
    set_req(1'b0, 3'b010, 32'h14, 32'h0, 5'd2);
    chk("b2b_ready_b", req_ready, 1);
    @(negedge clk);
    chk("b2b_cnt1", inflight_cnt, 1);
    chk("b2b_req_b", data_sram_addr, 32'h14);
    set_req(1'b0, 3'b010, 32'h18, 32'h0, 5'd3);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_cnt2", inflight_cnt, 2);
    chk("b2b_full_noreq", data_sram_req, 0);
    chk("b2b_full_notready", req_ready, 0);
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h111;
    @(negedge clk);
    data_sram_rdata = 32'h222;
    chk("b2b_resp_a_valid", resp_valid, 1);
    chk("b2b_resp_a_data", resp_data, 32'h111);
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", resp_valid, 1);
      chk("bp_hold_tag", resp_tag, 1);
      chk("bp_hold_noreq", data_sram_req, 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_resp_b_data", resp_data, 32'h222);
    chk("bp_resp_b_tag", resp_tag, 2);
    chk("bp_cnt_after_pop", inflight_cnt, 1);
    chk("bp_reuse_req", data_sram_req, 1);
    chk("bp_reuse_addr", data_sram_addr, 32'h18);
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    chk("bp_cnt_c", inflight_cnt, 1);
    chk("bp_no_resp", resp_valid, 0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h333;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    chk("bp_resp_c_data", resp_data, 32'h333);
    chk("bp_resp_c_tag", resp_tag, 3);
    @(negedge clk);
    chk("bp_idle", busy, 0);

    // Flush with one in flight and the slot presented, awaiting addr_ok.
    data_sram_addr_ok = 1'b1;
    set_req(1'b0, 3'b010, 32'h20, 32'h0, 5'd4);
    @(negedge clk);
    set_req(1'b0, 3'b010, 32'h24, 32'h0, 5'd5);
    @(negedge clk);
    req_valid = 1'b0; data_sram_addr_ok = 1'b0;
    chk("fl_presented", data_sram_req, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_slot_kept", data_sram_req, 1);
    chk("fl_slot_addr", data_sram_addr, 32'h24);
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    chk("fl_cnt2", inflight_cnt, 2);
    data_sram_data_ok = 1'b1;
    @(negedge clk);
    chk("fl_no_resp1", resp_valid, 0);
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    chk("fl_no_resp2", resp_valid, 0);
    @(negedge clk);
    chk("fl_no_resp3", resp_valid, 0);
    chk("fl_busy_off", busy, 0);
    flush = 1'b1;
    #1 chk("fl_ready_gated", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("fl_ready_back", req_ready, 1);

    // Flush with full buffer: the waiting slot is dropped without a bus request.
    @(negedge clk);
    data_sram_addr_ok = 1'b1;
    set_req(1'b1, 3'b010, 32'h30, 32'h5, 5'd6);
    @(negedge clk);
    set_req(1'b0, 3'b010, 32'h34, 32'h0, 5'd7);
    @(negedge clk);
    set_req(1'b0, 3'b010, 32'h38, 32'h0, 5'd8);
    @(negedge clk);
    req_valid = 1'b0; data_sram_addr_ok = 1'b0;
    chk("fd_full", inflight_cnt, 2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fd_dropped", data_sram_req, 0);
    data_sram_data_ok = 1'b1;
    @(negedge clk);
    chk("fd_no_resp1", resp_valid, 0);
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    chk("fd_no_resp2", resp_valid, 0);
    @(negedge clk);
    chk("fd_busy_off", busy, 0);
    chk("fd_no_req", data_sram_req, 0);

    // Reset mid-transaction, then a fresh LW.
    data_sram_addr_ok = 1'b1;
    set_req(1'b0, 3'b010, 32'h40, 32'h0, 5'd20);
    @(negedge clk);
    set_req(1'b0, 3'b010, 32'h44, 32'h0, 5'd21);
    @(negedge clk);
    req_valid = 1'b0; data_sram_addr_ok = 1'b0;
    chk("mr_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_bus_req", data_sram_req, 0);
    chk("mr_req_ready", req_ready, 1);
    chk("mr_cnt", inflight_cnt, 0);
    chk("mr_busy_off", busy, 0);
    chk("mr_resp_valid", resp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{1'b0, 3'b010, 32'h0000_5004, 32'h0, 32'h1357_9BDF, 5'd22, 4'b0000,
              32'h0, 2'd2, 32'h1357_9BDF}, 99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
